// File: rtl/alu_op_decoder_if.sv
// Handshake and decoded-field bundle between the fetch queue, the decoder and the ALU stage.
// The slave modport is the decoder's view; master is the upstream/downstream environment.
interface alu_op_decoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       op_code;
    logic [4:0]       shamt;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [4:0]       rd_addr;
    logic             wr_en;
    logic             is_jr;
    logic             illegal;
    logic [CNT_W-1:0] illegal_count;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, op_code, shamt, rs_addr, rt_addr, rd_addr,
               wr_en, is_jr, illegal, illegal_count
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, op_code, shamt, rs_addr, rt_addr, rd_addr,
               wr_en, is_jr, illegal, illegal_count
    );
endinterface

// File: rtl/alu_op_decoder.sv
// R-type MIPS decode stage: registered 1-cycle decode behind a 2-entry skid buffer,
// with a saturating count of accepted illegal instructions.
module alu_op_decoder #(
    parameter int         CNT_W      = 16,
    parameter logic [4:0] ILLEGAL_OP = 5'd12
) (
    input logic              clk,
    input logic              rst,
    alu_op_decoder_if.slave  bus
);
    typedef struct packed {
        logic [4:0] op;
        logic [4:0] shamt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_jr;
        logic       illegal;
    } dec_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam dec_t RST_FIELDS = '{ILLEGAL_OP, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d.op      = ILLEGAL_OP;
        d.illegal = 1'b1;
        d.shamt   = w[10:6];
        d.rs      = w[25:21];
        d.rt      = w[20:16];
        d.rd      = w[15:11];
        if (w == '0) begin
            d.op      = 5'd12;
            d.illegal = 1'b0;
        end else if (w[31:26] == '0) begin
            d.illegal = 1'b0;
            case (w[5:0])
                6'h20:   d.op = 5'd0;
                6'h21:   d.op = 5'd1;
                6'h22:   d.op = 5'd2;
                6'h23:   d.op = 5'd3;
                6'h24:   d.op = 5'd4;
                6'h25:   d.op = 5'd5;
                6'h27:   d.op = 5'd6;
                6'h2A:   d.op = 5'd7;
                6'h00:   d.op = 5'd8;
                6'h02:   d.op = 5'd9;
                6'h03:   d.op = 5'd10;
                6'h08:   d.op = 5'd11;
                default: begin
                    d.op      = ILLEGAL_OP;
                    d.illegal = 1'b1;
                end
            endcase
        end
        d.wr_en = !d.illegal && (d.op <= 5'd10) && (d.rd != 5'd0);
        d.is_jr = !d.illegal && (d.op == 5'd11);
        return d;
    endfunction

    logic [1:0]       state_q, state_d;
    dec_t             out_q, out_d;
    dec_t             skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept, deliver;
    dec_t dec_in;

    assign dec_in  = decode(bus.instr);
    assign accept  = bus.in_valid && in_ready_q;
    assign deliver = (state_q != ST_EMPTY) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    out_d   = dec_in;
                end
            end
            ST_ONE: begin
                if (accept && deliver) begin
                    out_d = dec_in;
                end else if (accept) begin
                    state_d = ST_TWO;
                    skid_d  = dec_in;
                end else if (deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so a delivery can only promote the skid entry
                if (deliver) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (accept && dec_in.illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_q      <= RST_FIELDS;
            skid_q     <= RST_FIELDS;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = (state_q != ST_EMPTY);
    assign bus.op_code       = out_q.op;
    assign bus.shamt         = out_q.shamt;
    assign bus.rs_addr       = out_q.rs;
    assign bus.rt_addr       = out_q.rt;
    assign bus.rd_addr       = out_q.rd;
    assign bus.wr_en         = out_q.wr_en;
    assign bus.is_jr         = out_q.is_jr;
    assign bus.illegal       = out_q.illegal;
    assign bus.illegal_count = cnt_q;
endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: directed scenarios plus random traffic, checked against
// a queue-based FIFO model and a table-lookup decode reference.
module tb_alu_op_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_op_decoder_if #(.CNT_W(16)) bus ();
    alu_op_decoder_if #(.CNT_W(2))  b2 ();

    alu_op_decoder #(.CNT_W(16), .ILLEGAL_OP(5'd12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_op_decoder #(.CNT_W(2), .ILLEGAL_OP(5'd12)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    typedef struct packed {
        logic [4:0] op;
        logic [4:0] shamt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_jr;
        logic       illegal;
    } exp_t;

    int unsigned functs [12] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h27, 'h2A, 'h00, 'h02, 'h03, 'h08};

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t q[$];
    int   cnt_m    = 0;

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int   op  = 12;
        logic bad = 1'b1;
        if (w == 32'h0) begin
            bad = 1'b0;
        end else if (w[31:26] == 6'd0) begin
            for (int i = 0; i < 12; i++)
                if (w[5:0] == functs[i][5:0]) begin
                    op  = i;
                    bad = 1'b0;
                end
        end
        e.op      = 5'(op);
        e.shamt   = w[10:6];
        e.rs      = w[25:21];
        e.rt      = w[20:16];
        e.rd      = w[15:11];
        e.illegal = bad;
        e.wr_en   = !bad && op <= 10 && w[15:11] != 5'd0;
        e.is_jr   = !bad && op == 11;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_fields();
        exp_t o;
        o = '{bus.op_code, bus.shamt, bus.rs_addr, bus.rt_addr, bus.rd_addr,
              bus.wr_en, bus.is_jr, bus.illegal};
        return 32'(o);
    endfunction

    // Check visible state against the model, then advance one clock with the given inputs.
    task automatic step(input logic v, input logic [31:0] w, input logic r, input logic rs);
        logic acc, del;
        bus.in_valid  = v;
        bus.instr     = w;
        bus.out_ready = r;
        rst           = rs;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("illegal_count", 32'(bus.illegal_count), 32'(cnt_m));
        if (q.size() > 0) chk("fields", obs_fields(), 32'(q[0]));
        acc = v && q.size() < 2;
        del = r && q.size() > 0;
        @(posedge clk);
        if (rs) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (del) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_decode(w));
                if (ref_decode(w).illegal && cnt_m != 65535) cnt_m++;
            end
        end
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count", 32'(bus.illegal_count), 32'd0);
        chk("rst_fields", obs_fields(), 32'({5'd12, 23'd0}));
    endtask

    initial begin
        logic [31:0] r, w;
        bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b0;
        b2.in_valid  = 1'b0; b2.instr  = '0; b2.out_ready  = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_reset_state();

        // 1: add $3,$1,$2
        step(1'b1, 32'h00221820, 1'b1, 1'b0);
        chk("t1_op", 32'(bus.op_code), 32'd0);
        chk("t1_rd", 32'(bus.rd_addr), 32'd3);
        chk("t1_wr_en", 32'(bus.wr_en), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // 2: back-to-back stream
        step(1'b1, 32'h000521C0, 1'b1, 1'b0);
        chk("t2_sll_op", 32'(bus.op_code), 32'd8);
        chk("t2_sll_shamt", 32'(bus.shamt), 32'd7);
        step(1'b1, 32'h03E00008, 1'b1, 1'b0);
        chk("t2_jr_isjr", 32'(bus.is_jr), 32'd1);
        chk("t2_jr_wr_en", 32'(bus.wr_en), 32'd0);
        step(1'b1, 32'h00000000, 1'b1, 1'b0);
        chk("t2_nop_op", 32'(bus.op_code), 32'd12);
        chk("t2_nop_illegal", 32'(bus.illegal), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // 3: stall downstream, third word refused until space frees
        step(1'b1, 32'h00221820, 1'b0, 1'b0);
        step(1'b1, 32'h00642022, 1'b0, 1'b0);
        chk("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
        step(1'b1, 32'h00A63025, 1'b0, 1'b0);
        step(1'b1, 32'h00A63025, 1'b1, 1'b0);
        step(1'b1, 32'h00A63025, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // 4: illegal words
        step(1'b1, 32'h8C220000, 1'b1, 1'b0);
        chk("t4_lw_illegal", 32'(bus.illegal), 32'd1);
        chk("t4_lw_op", 32'(bus.op_code), 32'd12);
        chk("t4_count1", 32'(bus.illegal_count), 32'd1);
        step(1'b1, 32'h0022183F, 1'b1, 1'b0);
        chk("t4_count2", 32'(bus.illegal_count), 32'd2);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // 5: saturation with a 2-bit counter
        b2.in_valid = 1'b1; b2.instr = 32'h8C220000; b2.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            chk("t5_sat_count", 32'(b2.illegal_count), 32'((i < 3) ? i : 3));
        end
        b2.in_valid = 1'b0;

        // 6: reset while holding two entries, with a handshake in the reset cycle
        step(1'b1, 32'h00221820, 1'b0, 1'b0);
        step(1'b1, 32'h8C220000, 1'b0, 1'b0);
        step(1'b1, 32'h00642022, 1'b1, 1'b1);
        chk_reset_state();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            case ($urandom_range(0, 3))
                0: w = {6'd0, r[25:6], functs[$urandom_range(0, 11)][5:0]};
                1: w = r;
                2: w = {6'd0, r[25:0]};
                default: w = 32'h0;
            endcase
            step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 2) != 0), 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
